// File: rtl/perf_monitor.sv
// Retire-stage performance monitor: debug pass-through, saturating
// event counters, halt detection and a registered counter read port.
module perf_monitor #(
    parameter int          CNT_W   = 32,
    parameter logic [31:0] HALT_PC = 32'h0000_001C
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wb_vld,
    input  logic [31:0]      i_wb_pc,
    input  logic             i_wb_ctrl,
    input  logic             i_wb_mispred,
    input  logic             i_clr,
    input  logic             i_freeze,
    input  logic [2:0]       i_rd_addr,
    output logic [CNT_W-1:0] o_rd_data,
    output logic [31:0]      o_pc_debug,
    output logic             o_insn_vld,
    output logic             o_ctrl,
    output logic             o_mispred,
    output logic             o_halt
);

    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ins_q, ins_d;
    logic [CNT_W-1:0] ctl_q, ctl_d;
    logic [CNT_W-1:0] mis_q, mis_d;
    logic [CNT_W-1:0] rd_q, rd_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      last_pc_q, last_pc_d;
    logic             vld_q, vld_d;
    logic             ctl_o_q, ctl_o_d;
    logic             mis_o_q, mis_o_d;
    logic             halt_q, halt_d;
    logic             err_q, err_d;

    logic             active;
    logic             ev_ctl;
    logic             ev_mis;
    logic [CNT_W-1:0] status_ext;
    logic [CNT_W-1:0] pc_ext;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v,
        input logic             en
    );
        if (en && !(&v)) return v + {{(CNT_W-1){1'b0}}, 1'b1};
        return v;
    endfunction

    assign active = !i_freeze && !halt_q;
    assign ev_ctl = i_wb_vld && i_wb_ctrl;
    assign ev_mis = ev_ctl && i_wb_mispred;

    assign status_ext = {{(CNT_W-3){1'b0}}, err_q, halt_q, i_freeze};

    // Last PC is 32 bits wide; fit it to the counter width
    generate
        if (CNT_W > 32) begin : g_pc_wide
            assign pc_ext = {{(CNT_W-32){1'b0}}, last_pc_q};
        end else if (CNT_W == 32) begin : g_pc_eq
            assign pc_ext = last_pc_q;
        end else begin : g_pc_narrow
            assign pc_ext = last_pc_q[CNT_W-1:0];
        end
    endgenerate

    always_comb begin
        cyc_d     = cyc_q;
        ins_d     = ins_q;
        ctl_d     = ctl_q;
        mis_d     = mis_q;
        halt_d    = halt_q;
        err_d     = err_q;
        last_pc_d = last_pc_q;
        pc_d      = i_wb_pc;
        vld_d     = i_wb_vld;
        ctl_o_d   = ev_ctl;
        mis_o_d   = ev_mis;

        if (i_wb_vld) last_pc_d = i_wb_pc;

        if (i_clr) begin
            cyc_d  = '0;
            ins_d  = '0;
            ctl_d  = '0;
            mis_d  = '0;
            halt_d = 1'b0;
            err_d  = 1'b0;
        end else begin
            cyc_d = sat_inc(cyc_q, active);
            ins_d = sat_inc(ins_q, active && i_wb_vld);
            ctl_d = sat_inc(ctl_q, active && ev_ctl);
            mis_d = sat_inc(mis_q, active && ev_mis);
            if (i_wb_vld && i_wb_mispred && !i_wb_ctrl) err_d = 1'b1;
            if (i_wb_vld && (i_wb_pc == HALT_PC)) halt_d = 1'b1;
        end

        case (i_rd_addr)
            3'd0:    rd_d = cyc_q;
            3'd1:    rd_d = ins_q;
            3'd2:    rd_d = ctl_q;
            3'd3:    rd_d = mis_q;
            3'd4:    rd_d = status_ext;
            3'd5:    rd_d = pc_ext;
            default: rd_d = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cyc_q     <= '0;
            ins_q     <= '0;
            ctl_q     <= '0;
            mis_q     <= '0;
            rd_q      <= '0;
            pc_q      <= '0;
            last_pc_q <= '0;
            vld_q     <= 1'b0;
            ctl_o_q   <= 1'b0;
            mis_o_q   <= 1'b0;
            halt_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cyc_q     <= cyc_d;
            ins_q     <= ins_d;
            ctl_q     <= ctl_d;
            mis_q     <= mis_d;
            rd_q      <= rd_d;
            pc_q      <= pc_d;
            last_pc_q <= last_pc_d;
            vld_q     <= vld_d;
            ctl_o_q   <= ctl_o_d;
            mis_o_q   <= mis_o_d;
            halt_q    <= halt_d;
            err_q     <= err_d;
        end
    end

    assign o_rd_data  = rd_q;
    assign o_pc_debug = pc_q;
    assign o_insn_vld = vld_q;
    assign o_ctrl     = ctl_o_q;
    assign o_mispred  = mis_o_q;
    assign o_halt     = halt_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: vector table for the retire/halt
// run plus hand sequences for freeze, error, saturation and reset.
module tb_perf_monitor;

    logic        clk;
    logic        rst_n;
    logic        vld;
    logic [31:0] pc;
    logic        ctrl;
    logic        mp;
    logic        clr;
    logic        frz;
    logic [2:0]  addr;

    logic [31:0] rd32;
    logic [31:0] pcd;
    logic        ov, oc, om, oh;
    logic [7:0]  rd8;
    logic [31:0] pcd8;
    logic        ov8, oc8, om8, oh8;

    int n_pass = 0;
    int n_tot  = 0;

    perf_monitor #(.CNT_W(32)) u_dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_wb_vld(vld), .i_wb_pc(pc), .i_wb_ctrl(ctrl),
        .i_wb_mispred(mp), .i_clr(clr), .i_freeze(frz),
        .i_rd_addr(addr), .o_rd_data(rd32), .o_pc_debug(pcd),
        .o_insn_vld(ov), .o_ctrl(oc), .o_mispred(om), .o_halt(oh)
    );

    perf_monitor #(.CNT_W(8)) u_dut8 (
        .i_clk(clk), .i_reset(rst_n),
        .i_wb_vld(vld), .i_wb_pc(pc), .i_wb_ctrl(ctrl),
        .i_wb_mispred(mp), .i_clr(clr), .i_freeze(frz),
        .i_rd_addr(addr), .o_rd_data(rd8), .o_pc_debug(pcd8),
        .o_insn_vld(ov8), .o_ctrl(oc8), .o_mispred(om8), .o_halt(oh8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [31:0] pc;
        logic        ctrl;
        logic        mp;
        logic        clr;
        logic [2:0]  addr;
        logic [31:0] e_rd;
        logic [31:0] e_pc;
        logic        e_vld;
        logic        e_ctl;
        logic        e_mis;
        logic        e_halt;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(
        input logic v, input logic [31:0] p, input logic c,
        input logic m, input logic cl, input logic [2:0] a,
        input logic [31:0] erd, input logic [31:0] epc,
        input logic ev, input logic ec, input logic em,
        input logic eh
    );
        vec_t r;
        r.vld = v; r.pc = p; r.ctrl = c; r.mp = m;
        r.clr = cl; r.addr = a; r.e_rd = erd; r.e_pc = epc;
        r.e_vld = ev; r.e_ctl = ec; r.e_mis = em; r.e_halt = eh;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        vld = 0; pc = 0; ctrl = 0; mp = 0; clr = 0; frz = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd"}, rd32, 0);
        chk({tag, "_pc"}, pcd, 0);
        chk({tag, "_vld"}, ov, 0);
        chk({tag, "_ctl"}, oc, 0);
        chk({tag, "_mis"}, om, 0);
        chk({tag, "_halt"}, oh, 0);
        chk({tag, "_rd8"}, rd8, 0);
    endtask

    initial begin
        idle_in();
        addr = 0;
        rst_n = 1;
        #1 rst_n = 0;
        #1 chk_all_zero("rst");

        @(posedge clk);
        #6 rst_n = 1;
        repeat (10) step();
        addr = 0;
        step();
        chk("idle_cyc", rd32, 10);
        for (int a = 1; a <= 3; a++) begin
            addr = 3'(a);
            step();
            chk($sformatf("idle_a%0d", a), rd32, 0);
        end
        chk("idle_pc", pcd, 0);
        chk("idle_vld", ov, 0);
        chk("idle_ctl", oc, 0);
        chk("idle_mis", om, 0);

        //        vld pc      c  m  clr a  rd     epc     v  c  m  h
        tbl[0]  = mk(0, 32'h00, 0, 0, 1, 4, 0,     32'h00, 0, 0, 0, 0);
        tbl[1]  = mk(1, 32'h00, 0, 0, 0, 1, 0,     32'h00, 1, 0, 0, 0);
        tbl[2]  = mk(1, 32'h04, 1, 0, 0, 1, 1,     32'h04, 1, 1, 0, 0);
        tbl[3]  = mk(1, 32'h08, 1, 1, 0, 2, 1,     32'h08, 1, 1, 1, 0);
        tbl[4]  = mk(0, 32'h0C, 1, 1, 0, 3, 1,     32'h0C, 0, 0, 0, 0);
        tbl[5]  = mk(1, 32'h0C, 0, 0, 0, 5, 8,     32'h0C, 1, 0, 0, 0);
        tbl[6]  = mk(1, 32'h10, 0, 0, 0, 0, 5,     32'h10, 1, 0, 0, 0);
        tbl[7]  = mk(1, 32'h14, 0, 0, 0, 5, 32'h10, 32'h14, 1, 0, 0, 0);
        tbl[8]  = mk(1, 32'h1C, 0, 0, 0, 4, 0,     32'h1C, 1, 0, 0, 1);
        tbl[9]  = mk(0, 32'h00, 0, 0, 0, 4, 2,     32'h00, 0, 0, 0, 1);
        tbl[10] = mk(1, 32'h20, 1, 1, 0, 1, 7,     32'h20, 1, 1, 1, 1);
        tbl[11] = mk(0, 32'h00, 0, 0, 0, 2, 2,     32'h00, 0, 0, 0, 1);
        tbl[12] = mk(0, 32'h00, 0, 0, 0, 3, 1,     32'h00, 0, 0, 0, 1);
        tbl[13] = mk(0, 32'h00, 0, 0, 0, 0, 8,     32'h00, 0, 0, 0, 1);

        for (int i = 0; i < 14; i++) begin
            vld = tbl[i].vld; pc = tbl[i].pc; ctrl = tbl[i].ctrl;
            mp = tbl[i].mp; clr = tbl[i].clr; addr = tbl[i].addr;
            step();
            chk($sformatf("v%0d_rd", i), rd32, tbl[i].e_rd);
            chk($sformatf("v%0d_pc", i), pcd, tbl[i].e_pc);
            chk($sformatf("v%0d_vld", i), ov, tbl[i].e_vld);
            chk($sformatf("v%0d_ctl", i), oc, tbl[i].e_ctl);
            chk($sformatf("v%0d_mis", i), om, tbl[i].e_mis);
            chk($sformatf("v%0d_halt", i), oh, tbl[i].e_halt);
        end
        idle_in();

        addr = 0;
        repeat (20) step();
        step();
        chk("halt_hold_cyc", rd32, 8);
        chk("halt_hold_flag", oh, 1);

        clr = 1;
        step();
        clr = 0;
        chk("clr_halt", oh, 0);
        repeat (3) step();
        for (int i = 0; i < 5; i++) begin
            frz = 1; ctrl = 1; mp = 1; addr = 4;
            vld = (i % 2 == 0);
            pc = 32'h40 + 32'(4 * i);
            step();
            chk($sformatf("frz%0d_vld", i), ov, (i % 2 == 0));
            chk($sformatf("frz%0d_ctl", i), oc, (i % 2 == 0));
            chk($sformatf("frz%0d_stat", i), rd32, 1);
        end
        idle_in();
        addr = 0; step(); chk("frz_cyc", rd32, 3);
        addr = 1; step(); chk("frz_ins", rd32, 0);
        addr = 2; step(); chk("frz_ctl", rd32, 0);
        addr = 3; step(); chk("frz_mis", rd32, 0);
        addr = 5; step(); chk("frz_lastpc", rd32, 32'h50);

        vld = 1; mp = 1; ctrl = 0; pc = 32'h60; addr = 0;
        step();
        idle_in();
        addr = 4; step(); chk("err_stat", rd32, 4);
        addr = 3; step(); chk("err_mis", rd32, 0);
        clr = 1; addr = 4; step(); chk("err_pre_clr", rd32, 4);
        clr = 0;
        addr = 0; step(); chk("clr_cyc", rd32, 0);
        addr = 4; step(); chk("clr_stat", rd32, 0);
        addr = 1; step(); chk("clr_ins", rd32, 0);
        addr = 2; step(); chk("clr_ctl", rd32, 0);
        addr = 3; step(); chk("clr_mis", rd32, 0);

        clr = 1; step(); clr = 0;
        addr = 0;
        repeat (300) step();
        step();
        chk("sat_cyc32", rd32, 300);
        chk("sat_cyc8", rd8, 8'hFF);
        repeat (5) step();
        chk("sat_hold8", rd8, 8'hFF);
        addr = 1; step(); chk("sat_ins8", rd8, 0);

        vld = 1; ctrl = 1; mp = 1; pc = 32'h70; addr = 0;
        step();
        chk("pre_rst_pc", pcd, 32'h70);
        #2 rst_n = 0;
        #1 chk_all_zero("mid_rst");
        idle_in();
        #2 rst_n = 1;
        addr = 0;
        repeat (5) step();
        step();
        chk("post_rst_cyc", rd32, 5);
        addr = 5; step(); chk("post_rst_lastpc", rd32, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
